// File: rtl/yd_boot_ctrl.sv
// Boot loader: receives a byte-stream image (count, words, optional checksum), writes it into
// instruction memory, then releases the core. Checksum support enabled by YD_BOOT_CSUM_EN.
module yd_boot_ctrl #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [AW-1:0] im_addr,
  output logic [DW-1:0] im_din,
  output logic          im_we,
  output logic          core_rst,
  input  logic          reload,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    StCntH, StCntL, StDatH, StDatL, StSumH, StSumL, StRun, StErr
  } state_e;

`ifdef YD_BOOT_CSUM_EN
  localparam state_e StAfterLoad = StSumH;
`else
  localparam state_e StAfterLoad = StRun;
`endif

  state_e        state_q, state_d;
  logic [7:0]    byte_hi_q, byte_hi_d;
  logic [15:0]   rem_q, rem_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] im_addr_q, im_addr_d;
  logic [DW-1:0] im_din_q, im_din_d;
  logic          im_we_q, im_we_d;
  logic          rx_ready_q, rx_ready_d;
  logic          core_rst_q, core_rst_d;
  logic          done_q, done_d;
  logic          xfer;
  logic [15:0]   word;
`ifdef YD_BOOT_CSUM_EN
  logic [15:0]   sum_q, sum_d;
  logic          err_q, err_d;
`endif

  // rx_ready is registered, so a transfer is judged against the flop, not the next state.
  assign xfer = rx_valid & rx_ready_q;
  assign word = {byte_hi_q, rx_data};

  always_comb begin
    state_d   = state_q;
    byte_hi_d = byte_hi_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    im_addr_d = im_addr_q;
    im_din_d  = im_din_q;
    im_we_d   = 1'b0;
`ifdef YD_BOOT_CSUM_EN
    sum_d     = sum_q;
`endif

    unique case (state_q)
      StCntH: begin
        if (xfer) begin
          byte_hi_d = rx_data;
          state_d   = StCntL;
        end
      end
      StCntL: begin
        if (xfer) begin
          rem_d   = word;
          state_d = (word == 16'd0) ? StAfterLoad : StDatH;
        end
      end
      StDatH: begin
        if (xfer) begin
          byte_hi_d = rx_data;
          state_d   = StDatL;
        end
      end
      StDatL: begin
        if (xfer) begin
          im_we_d   = 1'b1;
          im_din_d  = DW'(word);
          im_addr_d = addr_q;
          addr_d    = addr_q + AW'(1);
          rem_d     = rem_q - 16'd1;
`ifdef YD_BOOT_CSUM_EN
          sum_d     = sum_q + word;
`endif
          state_d   = (rem_q == 16'd1) ? StAfterLoad : StDatH;
        end
      end
`ifdef YD_BOOT_CSUM_EN
      StSumH: begin
        if (xfer) begin
          byte_hi_d = rx_data;
          state_d   = StSumL;
        end
      end
      StSumL: begin
        if (xfer) begin
          state_d = (word == sum_q) ? StRun : StErr;
        end
      end
      StErr: begin
        if (reload) begin
          state_d = StCntH;
        end
      end
`endif
      StRun: begin
        if (reload) begin
          state_d = StCntH;
        end
      end
      default: state_d = StCntH;
    endcase

    // A fresh load always starts at address 0 with a clean checksum.
    if (state_d == StCntH && state_q != StCntH) begin
      addr_d = '0;
`ifdef YD_BOOT_CSUM_EN
      sum_d  = '0;
`endif
    end

    rx_ready_d = (state_d != StRun) && (state_d != StErr);
    core_rst_d = (state_d != StRun);
    done_d     = (state_d == StRun);
`ifdef YD_BOOT_CSUM_EN
    err_d      = (state_d == StErr);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StCntH;
      byte_hi_q  <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      im_addr_q  <= '0;
      im_din_q   <= '0;
      im_we_q    <= 1'b0;
      rx_ready_q <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
`ifdef YD_BOOT_CSUM_EN
      sum_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_hi_q  <= byte_hi_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      im_addr_q  <= im_addr_d;
      im_din_q   <= im_din_d;
      im_we_q    <= im_we_d;
      rx_ready_q <= rx_ready_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
`ifdef YD_BOOT_CSUM_EN
      sum_q      <= sum_d;
      err_q      <= err_d;
`endif
    end
  end

  assign rx_ready = rx_ready_q;
  assign im_addr  = im_addr_q;
  assign im_din   = im_din_q;
  assign im_we    = im_we_q;
  assign core_rst = core_rst_q;
  assign done     = done_q;
`ifdef YD_BOOT_CSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: doc/yd_boot_ctrl.md
YD_BOOT_CTRL -- requirements
Module: yd_boot_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16, meaning instruction word width (fixed 16 in this revision).
REQ-002 SHALL have parameter AW, default 16, meaning instruction memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port rx_data  input  8  loader byte stream data.
REQ-006 SHALL have port rx_valid  input  1  rx_data valid.
REQ-007 SHALL have port rx_ready  output  1  block accepts byte; transfer = rx_valid & rx_ready on a rising edge.
REQ-008 SHALL have port im_addr  output  AW  instruction memory write address.
REQ-009 SHALL have port im_din  output  DW  instruction memory write data.
REQ-010 SHALL have port im_we  output  1  instruction memory write enable, high active.
REQ-011 SHALL have port core_rst  output  1  synchronous active-high reset to the core (its rst input).
REQ-012 SHALL have port reload  input  1  single-cycle request to re-enter load mode.
REQ-013 SHALL have port done  output  1  image loaded, core running.
REQ-014 SHALL have port err  output  1  load failed (checksum build only).

Function
REQ-015 SHALL implement states CNT_H, CNT_L, DAT_H, DAT_L, SUM_H, SUM_L, RUN, ERR; all outputs registered.
REQ-016 SHALL, in CNT_H/CNT_L, capture word count N high byte then low byte (16 bit).
REQ-017 SHALL, after CNT_L with N=0, go to SUM_H (checksum build) or RUN (otherwise); with N>0 go to DAT_H.
REQ-018 SHALL, in DAT_H, hold the byte as word[15:8]; in DAT_L, take word[7:0] and pulse im_we for exactly one cycle, the cycle after the DAT_L transfer, with im_din = full word.
REQ-019 SHALL write word k (0-based) at im_addr = k, address counter cleared on each entry to CNT_H, incrementing after each write, wrapping modulo 2^AW.
REQ-020 SHALL, after word N-1 is written, go to SUM_H (checksum build) or RUN (otherwise).
REQ-021 SHALL assert rx_ready in CNT_H..SUM_L only; deassert in RUN and ERR; no byte is consumed without rx_ready.
REQ-022 SHALL stall in any load state while rx_valid is low, with no state or counter change.
REQ-023 SHALL hold core_rst high in every state except RUN; core_rst falls on the first cycle state is RUN.
REQ-024 SHALL hold done high only in RUN, err high only in ERR.
REQ-025 SHALL, on reload high in RUN or ERR, enter CNT_H next cycle, asserting core_rst that cycle; reload in load states SHALL be ignored.
REQ-026 SHALL keep im_we low in all states except the single write cycle of REQ-018.

Reset
REQ-027 SHALL, while rst is low, force state CNT_H, counters/checksum 0, rx_ready 0, im_we 0, im_addr 0, im_din 0, core_rst 1, done 0, err 0.
REQ-028 SHALL assert rx_ready from the first rising edge after rst releases; rst low mid-load aborts the load and discards partial words.

Configuration
REQ-029 SHALL gate checksum support with macro YD_BOOT_CSUM_EN.
REQ-030 SHALL, with YD_BOOT_CSUM_EN defined, keep a 16-bit modulo-2^16 sum of all written words, receive a 16-bit checksum (high byte in SUM_H, low in SUM_L), and go to RUN if equal, else ERR.
REQ-031 SHALL, without YD_BOOT_CSUM_EN, omit SUM_H/SUM_L/ERR logic, tie err to 0 and go straight to RUN after the last word (or N=0).

Verification
REQ-032 SHALL cover: bytes 00 02 12 34 AB CD (no csum) -> writes 0x1234@0, 0xABCD@1, then core_rst 0, done 1, rx_ready 0.
REQ-033 SHALL cover: count 00 00 -> no im_we; RUN (no csum) or SUM_H awaiting 2 bytes (csum).
REQ-034 SHALL cover: csum build, image 00 02 12 34 AB CD BE 01 -> RUN; same image with checksum BE 02 -> ERR, err 1, core_rst stays 1.
REQ-035 SHALL cover: rx_valid gaps of 3 cycles between every byte -> identical writes and addresses as gap-free load.
REQ-036 SHALL cover: rst low after 3 bytes of a load, reload with 00 01 55 AA -> single write 0x55AA@0, done 1.
REQ-037 SHALL cover: reload pulse in RUN -> core_rst 1 next cycle, done 0, rx_ready 1, new image written from address 0.
